// File: rtl/seg_scan_driver.sv
// seg_scan_driver: self-scanning multiplexed seven-segment driver for DIGITS
// common-anode digits with active-low anodes and cathodes. It provides hex
// decode, a per-digit decimal point and blank, an anti-ghost dead time at the
// start of every digit slot, and tear-free data updates that take effect on
// frame boundaries.
// Optional feature macro: LEADING_ZERO_BLANK_EN (leading-zero suppression).
module seg_scan_driver #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD        = 500
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic [4*DIGITS-1:0]   dataIn,
   input  logic [DIGITS-1:0]     dpIn,
   input  logic [DIGITS-1:0]     blankIn,
   input  logic                  load,
   output logic [DIGITS-1:0]     anodes,
   output logic [7:0]            cathodes,
   output logic                  frameTick
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam int RW = $clog2(DIGITS);
   localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] DEAD_V    = PW'(DEAD);
   localparam logic [RW-1:0] RANK_MAX  = RW'(DIGITS - 1);

   // Reject unusable parameter sets while elaborating.
   generate
      if (DIGITS < 2 || DIGITS > 8) begin : g_bad_digits
         $error("seg_scan_driver: DIGITS must be in 2..8");
      end
      if (REFRESH_DIV <= DEAD + 1) begin : g_bad_div
         $error("seg_scan_driver: REFRESH_DIV must be at least DEAD+2");
      end
      if (DEAD < 1) begin : g_bad_dead
         $error("seg_scan_driver: DEAD must be at least 1");
      end
   endgenerate

   // Update handshake: load is a single-cycle strobe with no ready. Every
   // cycle with load=1 captures dataIn/dpIn/blankIn into the pending
   // register, and a later load overwrites it. The pending data moves to the
   // shadow register only on the frame-wrap cycle. A load on the wrap cycle
   // itself writes straight into the shadow register.

   logic [PW-1:0]         presc;
   logic [RW-1:0]         rank;
   logic                  frame_wrap;

   logic [4*DIGITS-1:0]   pend_data, shad_data;
   logic [DIGITS-1:0]     pend_dp, shad_dp;
   logic [DIGITS-1:0]     pend_blank, shad_blank;
   logic                  pend_valid;

   logic [DIGITS-1:0]     blank_eff;
   logic [3:0]            cur_nib;
   logic                  cur_dp;
   logic                  cur_blank;
   logic [DIGITS-1:0]     anodes_d;
   logic [7:0]            cathodes_d;

   // Hex to segments {g,f,e,d,c,b,a}, active low.
   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         default: hex7 = 7'h0E;
      endcase
   endfunction

   assign frame_wrap = (presc == PRESC_MAX) && (rank == RANK_MAX);

   // Slot prescaler and digit rank counter.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         presc <= '0;
         rank  <= '0;
      end else if (presc == PRESC_MAX) begin
         presc <= '0;
         rank  <= (rank == RANK_MAX) ? '0 : rank + RW'(1);
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // Pending/shadow update. The shadow register changes only at frame wrap.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pend_data  <= '0;
         pend_dp    <= '0;
         pend_blank <= '0;
         pend_valid <= 1'b0;
         shad_data  <= '0;
         shad_dp    <= '0;
         shad_blank <= '0;
      end else if (load && frame_wrap) begin
         shad_data  <= dataIn;
         shad_dp    <= dpIn;
         shad_blank <= blankIn;
         pend_valid <= 1'b0;
      end else if (load) begin
         pend_data  <= dataIn;
         pend_dp    <= dpIn;
         pend_blank <= blankIn;
         pend_valid <= 1'b1;
      end else if (frame_wrap && pend_valid) begin
         shad_data  <= pend_data;
         shad_dp    <= pend_dp;
         shad_blank <= pend_blank;
         pend_valid <= 1'b0;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // Effective blank: explicit blank plus leading-zero suppression from shadow.
   always_comb begin
      logic zero_run;
      zero_run  = 1'b1;
      blank_eff = shad_blank;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         zero_run = zero_run && (shad_data[4*k +: 4] == 4'h0);
         if (zero_run && !shad_dp[k]) begin
            blank_eff[k] = 1'b1;
         end
      end
   end
`else
   // Effective blank: only the explicit per-digit blank.
   always_comb begin
      blank_eff = shad_blank;
   end
`endif

   // Select the current digit and form the next anode/cathode pattern.
   always_comb begin
      cur_nib    = 4'h0;
      cur_dp     = 1'b0;
      cur_blank  = 1'b1;
      anodes_d   = '1;
      cathodes_d = 8'hFF;
      for (int k = 0; k < DIGITS; k++) begin
         if (rank == RW'(k)) begin
            cur_nib   = shad_data[4*k +: 4];
            cur_dp    = shad_dp[k];
            cur_blank = blank_eff[k];
         end
      end
      if (presc >= DEAD_V && !cur_blank) begin
         for (int k = 0; k < DIGITS; k++) begin
            anodes_d[k] = (rank != RW'(k));
         end
         cathodes_d = {~cur_dp, hex7(cur_nib)};
      end
   end

   // Registered pin drivers and the frame pulse.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         anodes    <= '1;
         cathodes  <= 8'hFF;
         frameTick <= 1'b0;
      end else begin
         anodes    <= anodes_d;
         cathodes  <= cathodes_d;
         frameTick <= frame_wrap;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized and directed bench for seg_scan_driver. A
// cycle-count reference model predicts frameTick, anodes and cathodes for
// every clock and puts the predictions in an expected queue.
module tb_seg_scan_driver;

   localparam int DIGITS = 4;
   localparam int RD     = 8;
   localparam int DEAD   = 2;
   localparam int FRAME  = RD * DIGITS;
   localparam int W      = 1 + DIGITS + 8;

   logic                 clk;
   logic                 resetN;
   logic [4*DIGITS-1:0]  dataIn;
   logic [DIGITS-1:0]    dpIn;
   logic [DIGITS-1:0]    blankIn;
   logic                 load;
   logic [DIGITS-1:0]    anodes;
   logic [7:0]           cathodes;
   logic                 frameTick;

   int n_checks;
   int n_errors;

   logic [W-1:0] exp_q[$];

   // Reference model state.
   int unsigned          m_t;
   logic [4*DIGITS-1:0]  m_pd, m_sd;
   logic [DIGITS-1:0]    m_pdp, m_pbl, m_sdp, m_sbl;
   bit                   m_pv;
   logic [7:0]           seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   seg_scan_driver #(.DIGITS(DIGITS), .REFRESH_DIV(RD), .DEAD(DEAD)) dut (
      .clk       (clk),
      .resetN    (resetN),
      .dataIn    (dataIn),
      .dpIn      (dpIn),
      .blankIn   (blankIn),
      .load      (load),
      .anodes    (anodes),
      .cathodes  (cathodes),
      .frameTick (frameTick)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (model cycle %0d)", tag, got, exp, m_t);
      end
   endtask

   task automatic model_reset();
      m_t   = 0;
      m_pd  = '0;
      m_pdp = '0;
      m_pbl = '0;
      m_pv  = 1'b0;
      m_sd  = '0;
      m_sdp = '0;
      m_sbl = '0;
      exp_q.delete();
   endtask

   // Predict the outputs for the coming edge, then advance the model.
   task automatic model_push();
      int         presc;
      int         rank;
      bit         wrap;
      bit         dark;
      bit         allz;
      logic [3:0] nib;
      logic [7:0] seg;
      logic [DIGITS-1:0] a;
      logic [7:0] c;
      presc = int'(m_t % RD);
      rank  = int'((m_t / RD) % DIGITS);
      wrap  = (presc == RD - 1) && (rank == DIGITS - 1);
      dark  = m_sbl[rank];
`ifdef LEADING_ZERO_BLANK_EN
      if (rank > 0 && !m_sdp[rank]) begin
         allz = 1'b1;
         for (int j = rank; j < DIGITS; j++) begin
            if (m_sd[4*j +: 4] != 4'h0) allz = 1'b0;
         end
         if (allz) dark = 1'b1;
      end
`else
      allz = 1'b0;
`endif
      a = '1;
      c = 8'hFF;
      if (presc >= DEAD && !dark) begin
         nib     = m_sd[4*rank +: 4];
         seg     = seg_tbl[nib];
         a[rank] = 1'b0;
         c       = {~m_sdp[rank], seg[6:0]};
      end
      exp_q.push_back({wrap, a, c});
      if (load && wrap) begin
         m_sd  = dataIn;
         m_sdp = dpIn;
         m_sbl = blankIn;
         m_pv  = 1'b0;
      end else if (load) begin
         m_pd  = dataIn;
         m_pdp = dpIn;
         m_pbl = blankIn;
         m_pv  = 1'b1;
      end else if (wrap && m_pv) begin
         m_sd  = m_pd;
         m_sdp = m_pdp;
         m_sbl = m_pbl;
         m_pv  = 1'b0;
      end
      m_t++;
   endtask

   // One clock: predict, let the edge happen, compare.
   task automatic step();
      logic [W-1:0] e;
      logic [W-1:0] got;
      model_push();
      @(posedge clk);
      #1;
      got = {frameTick, anodes, cathodes};
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check("frameTick", 32'(got[W-1]), 32'(e[W-1]));
         check("anodes", 32'(got[W-2 -: DIGITS]), 32'(e[W-2 -: DIGITS]));
         check("cathodes", 32'(got[7:0]), 32'(e[7:0]));
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Advance until the model sits at the given cycle within a frame (bounded).
   task automatic run_to_phase(input int phase);
      for (int i = 0; i < FRAME && int'(m_t % FRAME) != phase; i++) step();
   endtask

   task automatic do_load(input logic [4*DIGITS-1:0] d, input logic [DIGITS-1:0] dp,
                          input logic [DIGITS-1:0] bl);
      dataIn  = d;
      dpIn    = dp;
      blankIn = bl;
      load    = 1'b1;
      step();
      load    = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_anodes"}, 32'(anodes), 32'hF);
      check({tag, "_cathodes"}, 32'(cathodes), 32'hFF);
      check({tag, "_frameTick"}, 32'(frameTick), 32'h0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      resetN   = 1'b0;
      dataIn   = '0;
      dpIn     = '0;
      blankIn  = '0;
      load     = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      resetN = 1'b1;

      // Basic digits 1234, two frames plus a bit.
      do_load(16'h1234, 4'b0000, 4'b0000);
      run(2 * FRAME + 5);

      // Overwrite pending mid-frame; only the last load may show.
      run_to_phase(RD + 1);
      do_load(16'hABCD, 4'b0000, 4'b0000);
      run(6);
      do_load(16'h00EF, 4'b0000, 4'b0000);
      run(2 * FRAME);

      // Decimal point and blanking.
      do_load(16'h8888, 4'b0100, 4'b0001);
      run(2 * FRAME);

      // Load on the frame-wrap cycle goes straight to shadow.
      run_to_phase(FRAME - 1);
      do_load(16'h5555, 4'b0000, 4'b0000);
      run(2 * FRAME);

      // Random loads at random times, some aligned to the wrap cycle.
      for (int it = 0; it < 30; it++) begin
         run($urandom_range(0, 40));
         if ($urandom_range(0, 3) == 0) run_to_phase(FRAME - 1);
         do_load(16'($urandom), 4'($urandom),
                 ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000);
      end
      run(2 * FRAME);

      // Leading zeros (suppressed only when the feature is built in).
      do_load(16'h0070, 4'b0000, 4'b0000);
      run(2 * FRAME);
      do_load(16'h0000, 4'b0000, 4'b0000);
      run(2 * FRAME);

      // Asynchronous reset in the middle of a lit slot.
      run_to_phase(2 * RD + 5);
      resetN = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      @(posedge clk);
      #1;
      check_reset_outputs("held_reset");
      @(negedge clk);
      model_reset();
      resetN = 1'b1;
      run(FRAME + 3);
      do_load(16'($urandom), 4'($urandom), 4'b0000);
      run(2 * FRAME);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
